// File: rtl/rs_dsp_fir_sequencer.sv
// rs_dsp_fir_sequencer
// Feeds a single DSP38 (MULTIPLY_ADD_SUB, no input/output registers) one
// filter tap per cycle. Samples arrive on a valid/ready stream, shift into a
// TAPS-deep delay line, and are multiplied against a writable coefficient
// bank. The accumulated DSP Z is captured and returned on an output stream.
//
// Optional feature: define RS_FIR_OUTPUT_SCALE_EN to drive the DSP's
// saturate/round controls high and its shift-right input to SHIFT, so the
// result carries the DSP-scaled value instead of the raw accumulation.

module rs_dsp_fir_sequencer #(
    parameter int TAPS  = 8,
    parameter int SHIFT = 0
) (
    input  logic        clk,
    input  logic        lreset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [19:0] s_data,
    input  logic        coef_we,
    input  logic [4:0]  coef_addr,
    input  logic [17:0] coef_data,
    output logic [19:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic        dsp_load_acc,
    output logic [2:0]  dsp_feedback,
    output logic        dsp_unsigned_a,
    output logic        dsp_unsigned_b,
    output logic        dsp_subtract,
    output logic        dsp_saturate,
    output logic        dsp_round,
    output logic [5:0]  dsp_shift_right,
    input  logic [37:0] dsp_z,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [37:0] m_data,
    output logic        busy
);

    localparam int            KW        = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [KW-1:0] LAST_K    = KW'(TAPS - 1);
    localparam logic [5:0]    TAPS_6    = 6'(TAPS);
    localparam logic [5:0]    SHIFT_CFG = 6'(SHIFT);

`ifdef RS_FIR_OUTPUT_SCALE_EN
    localparam logic SCALE_EN = 1'b1;
`else
    localparam logic SCALE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic signed [19:0] x_q    [TAPS];
    logic signed [19:0] x_d    [TAPS];
    logic signed [17:0] coef_q [TAPS];
    logic signed [17:0] coef_d [TAPS];
    logic               s_ready_q, s_ready_d;
    logic               m_valid_q, m_valid_d;
    logic [37:0]        m_data_q, m_data_d;
    logic               coef_hit;

    // Coefficient writes land only while idle and only for in-range taps
    assign coef_hit = coef_we && (state_q == IDLE) && ({1'b0, coef_addr} < TAPS_6);

    // Next-state, delay line, coefficient bank and result capture
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        x_d       = x_q;
        coef_d    = coef_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;

        if (coef_hit) begin
            coef_d[coef_addr[KW-1:0]] = coef_data;
        end

        case (state_q)
            IDLE: begin
                if (s_valid && s_ready_q) begin
                    for (int i = 1; i < TAPS; i++) begin
                        x_d[i] = x_q[i-1];
                    end
                    x_d[0]  = s_data;
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (k_q == LAST_K) begin
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN: begin
                m_data_d  = dsp_z;
                m_valid_d = 1'b1;
                state_d   = OUT;
            end
            OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        s_ready_d = (state_d == IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (lreset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i]    <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            x_q       <= x_d;
            coef_q    <= coef_d;
        end
    end

    // DSP operand drive: one tap per MAC cycle, zeros everywhere else
    always_comb begin
        dsp_a        = '0;
        dsp_b        = '0;
        dsp_load_acc = 1'b0;
        if (state_q == MAC) begin
            dsp_a        = x_q[k_q];
            dsp_b        = coef_q[k_q];
            dsp_load_acc = (k_q == '0);
        end
    end

    assign dsp_feedback    = 3'b000;
    assign dsp_unsigned_a  = 1'b0;
    assign dsp_unsigned_b  = 1'b0;
    assign dsp_subtract    = 1'b0;
    assign dsp_saturate    = SCALE_EN;
    assign dsp_round       = SCALE_EN;
    assign dsp_shift_right = SCALE_EN ? SHIFT_CFG : 6'd0;

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_rs_dsp_fir_sequencer.sv
// Testbench for rs_dsp_fir_sequencer. Contains a behavioural DSP38
// accumulator (no input/output registers) and a transaction-level FIR model
// that predicts handshakes, DSP operands and results cycle by cycle.

module tb_rs_dsp_fir_sequencer;

    localparam int TAPS  = 4;
    localparam int SHIFT = 2;

    logic        clk = 1'b0;
    logic        lreset;
    logic        s_valid;
    logic        s_ready;
    logic [19:0] s_data;
    logic        coef_we;
    logic [4:0]  coef_addr;
    logic [17:0] coef_data;
    logic [19:0] dsp_a;
    logic [17:0] dsp_b;
    logic        dsp_load_acc;
    logic [2:0]  dsp_feedback;
    logic        dsp_unsigned_a;
    logic        dsp_unsigned_b;
    logic        dsp_subtract;
    logic        dsp_saturate;
    logic        dsp_round;
    logic [5:0]  dsp_shift_right;
    logic [37:0] dsp_z;
    logic        m_valid;
    logic        m_ready;
    logic [37:0] m_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rs_dsp_fir_sequencer #(.TAPS(TAPS), .SHIFT(SHIFT)) dut (
        .clk             (clk),
        .lreset          (lreset),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .coef_we         (coef_we),
        .coef_addr       (coef_addr),
        .coef_data       (coef_data),
        .dsp_a           (dsp_a),
        .dsp_b           (dsp_b),
        .dsp_load_acc    (dsp_load_acc),
        .dsp_feedback    (dsp_feedback),
        .dsp_unsigned_a  (dsp_unsigned_a),
        .dsp_unsigned_b  (dsp_unsigned_b),
        .dsp_subtract    (dsp_subtract),
        .dsp_saturate    (dsp_saturate),
        .dsp_round       (dsp_round),
        .dsp_shift_right (dsp_shift_right),
        .dsp_z           (dsp_z),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .busy            (busy)
    );

    // Unregistered DSP38: accumulator loads or adds A*B at every edge
    logic signed [37:0] aExt, bExt, dspProd, dspAcc;
    assign aExt    = {{18{dsp_a[19]}}, dsp_a};
    assign bExt    = {{20{dsp_b[17]}}, dsp_b};
    assign dspProd = aExt * bExt;
    assign dsp_z   = dspAcc;

    always @(posedge clk) begin
        if (lreset)            dspAcc <= '0;
        else if (dsp_load_acc) dspAcc <= dspProd;
        else                   dspAcc <= dspAcc + dspProd;
    end

    // Reference model state: phase 0 idle, 1 computing, 2 result waiting
    int          phase = 0;
    int          cnt   = 0;
    longint      hist  [TAPS];
    longint      coefM [TAPS];
    longint      accSum;
    logic [37:0] pendExp;
    logic [37:0] mDataExp;
    logic        mValidExp;
    logic [37:0] gotQ [$];
    logic [37:0] lastMData;
    logic        lastMValid;
    bit          checkEn = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] s38(input longint v);
        logic [63:0] t;
        t = v;
        return {26'd0, t[37:0]};
    endfunction

    // Result k of the model follows the plain FIR sum over the delay history
    always @(posedge clk) begin
        if (lreset) begin
            phase     = 0;
            cnt       = 0;
            mValidExp = 1'b0;
            mDataExp  = '0;
            for (int i = 0; i < TAPS; i++) begin
                hist[i]  = 0;
                coefM[i] = 0;
            end
        end else begin
            if (phase == 2 && m_ready) gotQ.push_back(lastMData);
            if (coef_we && phase == 0 && int'(coef_addr) < TAPS)
                coefM[int'(coef_addr)] = longint'($signed(coef_data));
            case (phase)
                0: if (s_valid) begin
                    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
                    hist[0] = longint'($signed(s_data));
                    accSum = 0;
                    for (int k = 0; k < TAPS; k++) accSum += hist[k] * coefM[k];
                    pendExp = accSum[37:0];
                    phase   = 1;
                    cnt     = TAPS + 1;
                end
                1: begin
                    cnt--;
                    if (cnt == 0) begin
                        phase     = 2;
                        mValidExp = 1'b1;
                        mDataExp  = pendExp;
                    end
                end
                default: if (m_ready) begin
                    phase     = 0;
                    mValidExp = 1'b0;
                end
            endcase
        end
    end

    // Per-cycle comparison of every output against the model
    logic [63:0] tapVal;
    int          kExp;
    always @(negedge clk) begin
        lastMData  = m_data;
        lastMValid = m_valid;
        if (checkEn) begin
            checkOutput("s_ready", s_ready, phase == 0);
            checkOutput("busy", busy, phase != 0);
            checkOutput("m_valid", m_valid, mValidExp);
            checkOutput("m_data", m_data, mDataExp);
            if (phase == 1 && cnt >= 2) begin
                kExp   = TAPS + 1 - cnt;
                tapVal = hist[kExp];
                checkOutput("dsp_a", dsp_a, tapVal[19:0]);
                tapVal = coefM[kExp];
                checkOutput("dsp_b", dsp_b, tapVal[17:0]);
                checkOutput("dsp_load_acc", dsp_load_acc, kExp == 0);
            end else begin
                checkOutput("dsp_a_idle", dsp_a, 0);
                checkOutput("dsp_b_idle", dsp_b, 0);
                checkOutput("dsp_load_acc_idle", dsp_load_acc, 0);
            end
            checkOutput("dsp_const", {dsp_feedback, dsp_unsigned_a, dsp_unsigned_b, dsp_subtract}, 0);
        end
    end

    task automatic applyStimulus(input logic sv, input logic [19:0] sd, input logic we,
                                 input logic [4:0] addr, input logic [17:0] cd, input logic mr);
        s_valid   = sv;
        s_data    = sd;
        coef_we   = we;
        coef_addr = addr;
        coef_data = cd;
        m_ready   = mr;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 20'd0, 1'b0, 5'd0, 18'd0, 1'b1);
    endtask

    task automatic checkGot(input string tag, input int idx, input longint expv);
        logic [63:0] g;
        g = (idx < gotQ.size()) ? {26'd0, gotQ[idx]} : 64'hx;
        checkOutput(tag, g, s38(expv));
    endtask

    // Watchdog so a stuck run still ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        lreset = 1'b1;
        applyStimulus(1'b0, 20'd0, 1'b0, 5'd0, 18'd0, 1'b1);
        checkEn = 1'b1;
        applyStimulus(1'b0, 20'd0, 1'b0, 5'd0, 18'd0, 1'b1);
        lreset = 1'b0;

`ifdef RS_FIR_OUTPUT_SCALE_EN
        checkOutput("cfg_saturate", dsp_saturate, 1);
        checkOutput("cfg_round", dsp_round, 1);
        checkOutput("cfg_shift", dsp_shift_right, 2);
`else
        checkOutput("cfg_saturate", dsp_saturate, 0);
        checkOutput("cfg_round", dsp_round, 0);
        checkOutput("cfg_shift", dsp_shift_right, 0);
`endif

        // Impulse through coefficients 1..4
        for (int i = 0; i < TAPS; i++)
            applyStimulus(1'b0, 20'd0, 1'b1, 5'(i), 18'(i + 1), 1'b1);
        gotQ.delete();
        for (int i = 0; i < TAPS; i++) begin
            applyStimulus(1'b1, (i == 0) ? 20'd1 : 20'd0, 1'b0, 5'd0, 18'd0, 1'b1);
            idleCycles(TAPS + 2);
        end
        checkOutput("impulse_count", gotQ.size(), 4);
        for (int i = 0; i < TAPS; i++) checkGot("impulse", i, longint'(i + 1));

        // Signed operands with every coefficient at -2
        for (int i = 0; i < TAPS; i++)
            applyStimulus(1'b0, 20'd0, 1'b1, 5'(i), 18'h3FFFE, 1'b1);
        gotQ.delete();
        applyStimulus(1'b1, 20'hFFFFD, 1'b0, 5'd0, 18'd0, 1'b1);
        idleCycles(TAPS + 2);
        applyStimulus(1'b1, 20'h00005, 1'b0, 5'd0, 18'd0, 1'b1);
        idleCycles(TAPS + 2);
        checkGot("signed_first", 0, 6);
        checkGot("signed_second", 1, -4);

        // Backpressure: result held, the waiting sample is not consumed
        gotQ.delete();
        applyStimulus(1'b1, 20'd7, 1'b0, 5'd0, 18'd0, 1'b0);
        repeat (TAPS + 11) applyStimulus(1'b1, 20'd9, 1'b0, 5'd0, 18'd0, 1'b0);
        checkOutput("bp_held_valid", m_valid, 1);
        checkOutput("bp_no_handshake", gotQ.size(), 0);
        applyStimulus(1'b0, 20'd0, 1'b0, 5'd0, 18'd0, 1'b1);
        checkOutput("bp_s_ready_after", s_ready, 1);
        idleCycles(2);
        checkGot("bp_result", 0, -18);

        // Coefficient lockout during MAC, then same write applied in IDLE
        gotQ.delete();
        applyStimulus(1'b1, 20'd1, 1'b0, 5'd0, 18'd0, 1'b1);
        applyStimulus(1'b0, 20'd0, 1'b1, 5'd0, 18'd100, 1'b1);
        idleCycles(TAPS + 1);
        applyStimulus(1'b1, 20'd2, 1'b1, 5'd0, 18'd100, 1'b1);
        idleCycles(TAPS + 2);
        checkGot("lockout_old_coef", 0, -20);
        checkGot("lockout_new_coef", 1, 174);

        // Reset while the tap counter is at 2
        applyStimulus(1'b1, 20'd3, 1'b0, 5'd0, 18'd0, 1'b1);
        idleCycles(2);
        lreset = 1'b1;
        applyStimulus(1'b0, 20'd0, 1'b0, 5'd0, 18'd0, 1'b1);
        lreset = 1'b0;
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_s_ready", s_ready, 1);
        for (int i = 0; i < TAPS; i++)
            applyStimulus(1'b0, 20'd0, 1'b1, 5'(i), 18'(i + 1), 1'b1);
        gotQ.delete();
        applyStimulus(1'b1, 20'd1, 1'b0, 5'd0, 18'd0, 1'b1);
        idleCycles(TAPS + 2);
        checkGot("rst_impulse", 0, 1);

        // Random traffic: streams, coefficient writes (some out of range), resets
        for (int n = 0; n < 600; n++) begin
            lreset = ($urandom_range(0, 149) == 0);
            applyStimulus(1'($urandom_range(0, 1)), 20'($urandom), 1'($urandom_range(0, 3) == 0),
                          5'($urandom_range(0, 7)), 18'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        lreset = 1'b0;
        idleCycles(TAPS + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
